// File: rtl/wptr_full_ctrl.sv
// Write-side pointer and full-flag logic for an asynchronous FIFO.
// Keeps a binary write pointer, publishes its Gray form to the read domain,
// and derives registered full / almost-full flags plus a sticky overflow flag.
module wptr_full_ctrl #(
    parameter int unsigned ASIZE      = 4,
    parameter int unsigned AWFULLSIZE = 1
) (
    input  logic             wclk,
    input  logic             wrst,
    input  logic             winc,
    input  logic [ASIZE:0]   wq2_rptr,
    output logic [ASIZE-1:0] waddr,
    output logic [ASIZE:0]   wptr,
    output logic             wfull,
    output logic             awfull,
    output logic             wovf
);

    localparam int unsigned   Depth     = 1 << ASIZE;
    localparam logic [ASIZE:0] AwfThresh = (ASIZE + 1)'(Depth - AWFULLSIZE);

    logic [ASIZE:0] wbin_q, wbin_d;
    logic [ASIZE:0] wptr_q, wptr_d;
    logic           wfull_q, wfull_d;
    logic           awfull_q, awfull_d;
    logic           wovf_q, wovf_d;

    logic           wr_accept;
    logic [ASIZE:0] rbin;
    logic [ASIZE:0] fill;
    logic [ASIZE:0] full_gray;

    // Next-pointer and flag computation; both flags use the same next pointer
    always_comb begin
        wr_accept = winc & ~wfull_q;
        wbin_d    = wbin_q + {{ASIZE{1'b0}}, wr_accept};
        wptr_d    = wbin_d ^ (wbin_d >> 1);

        // Gray to binary: bit i is the XOR of all Gray bits at or above i
        rbin = '0;
        for (int i = 0; i <= int'(ASIZE); i++) begin
            rbin[i] = ^(wq2_rptr >> i);
        end

        fill = wbin_d - rbin;

        // Full when write pointer is exactly one lap ahead of the read pointer
        full_gray = {~wq2_rptr[ASIZE:ASIZE-1], wq2_rptr[ASIZE-2:0]};
        wfull_d   = (wptr_d == full_gray);

        // Full implies almost-full even when fill would wrap the comparison
        awfull_d = (fill >= AwfThresh) | wfull_d;

        wovf_d = wovf_q | (winc & wfull_q);
    end

    // State registers with asynchronous active-high reset
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            wbin_q   <= '0;
            wptr_q   <= '0;
            wfull_q  <= 1'b0;
            awfull_q <= 1'b0;
            wovf_q   <= 1'b0;
        end else begin
            wbin_q   <= wbin_d;
            wptr_q   <= wptr_d;
            wfull_q  <= wfull_d;
            awfull_q <= awfull_d;
            wovf_q   <= wovf_d;
        end
    end

    // Output mapping; waddr is the pre-edge address of the current write
    always_comb begin
        waddr  = wbin_q[ASIZE-1:0];
        wptr   = wptr_q;
        wfull  = wfull_q;
        awfull = awfull_q;
        wovf   = wovf_q;
    end

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Self-checking bench for wptr_full_ctrl with ASIZE=4, AWFULLSIZE=1.
module tb_wptr_full_ctrl;

    logic       wclk = 1'b0;
    logic       wrst;
    logic       winc;
    logic [4:0] wq2_rptr;
    logic [3:0] waddr;
    logic [4:0] wptr;
    logic       wfull;
    logic       awfull;
    logic       wovf;

    int checks   = 0;
    int failures = 0;

    wptr_full_ctrl #(
        .ASIZE      (4),
        .AWFULLSIZE (1)
    ) dut (
        .wclk     (wclk),
        .wrst     (wrst),
        .winc     (winc),
        .wq2_rptr (wq2_rptr),
        .waddr    (waddr),
        .wptr     (wptr),
        .wfull    (wfull),
        .awfull   (awfull),
        .wovf     (wovf)
    );

    always #5 wclk = ~wclk;

    typedef struct {
        logic       winc;
        logic [4:0] rptr;
        logic [3:0] waddr;
        logic [4:0] wptr;
        logic       wfull;
        logic       awfull;
        logic       wovf;
    } vec_t;

    vec_t vecs[21];

    function automatic logic [4:0] gray(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] ea, input logic [4:0] ep,
                           input logic ef, input logic eaf, input logic eov);
        chk({tag, " waddr"}, 32'(waddr), 32'(ea));
        chk({tag, " wptr"}, 32'(wptr), 32'(ep));
        chk({tag, " wfull"}, 32'(wfull), 32'(ef));
        chk({tag, " awfull"}, 32'(awfull), 32'(eaf));
        chk({tag, " wovf"}, 32'(wovf), 32'(eov));
    endtask

    // Pulse reset between clock edges and check the asynchronous clear
    task automatic pulse_reset(input string tag);
        @(negedge wclk);
        winc = 1'b0;
        wrst = 1'b1;
        #1;
        chk_all(tag, 4'd0, 5'b00000, 1'b0, 1'b0, 1'b0);
        @(negedge wclk);
        wrst = 1'b0;
    endtask

    initial begin
        logic [4:0] wb;
        logic [4:0] rb;
        logic       saw_full;

        // Fill 16, overflow 3, release by one read, then refill to full
        vecs[0]  = '{1'b1, 5'b00000, 4'd1,  5'b00001, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 5'b00000, 4'd2,  5'b00011, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 5'b00000, 4'd3,  5'b00010, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 5'b00000, 4'd4,  5'b00110, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 5'b00000, 4'd5,  5'b00111, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 5'b00000, 4'd6,  5'b00101, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 5'b00000, 4'd7,  5'b00100, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 5'b00000, 4'd8,  5'b01100, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 5'b00000, 4'd9,  5'b01101, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 5'b00000, 4'd10, 5'b01111, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 5'b00000, 4'd11, 5'b01110, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 5'b00000, 4'd12, 5'b01010, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 5'b00000, 4'd13, 5'b01011, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 5'b00000, 4'd14, 5'b01001, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 5'b00000, 4'd15, 5'b01000, 1'b0, 1'b1, 1'b0};
        vecs[15] = '{1'b1, 5'b00000, 4'd0,  5'b11000, 1'b1, 1'b1, 1'b0};
        vecs[16] = '{1'b1, 5'b00000, 4'd0,  5'b11000, 1'b1, 1'b1, 1'b1};
        vecs[17] = '{1'b1, 5'b00000, 4'd0,  5'b11000, 1'b1, 1'b1, 1'b1};
        vecs[18] = '{1'b1, 5'b00000, 4'd0,  5'b11000, 1'b1, 1'b1, 1'b1};
        vecs[19] = '{1'b0, 5'b00001, 4'd0,  5'b11000, 1'b0, 1'b1, 1'b1};
        vecs[20] = '{1'b1, 5'b00001, 4'd1,  5'b11001, 1'b1, 1'b1, 1'b1};

        // Power-on reset, checked before the first clock edge
        wrst     = 1'b1;
        winc     = 1'b0;
        wq2_rptr = 5'b00000;
        #2;
        chk_all("por", 4'd0, 5'b00000, 1'b0, 1'b0, 1'b0);
        @(negedge wclk);
        wrst = 1'b0;

        // Table-driven fill / overflow / release
        for (int i = 0; i < 21; i++) begin
            winc     = vecs[i].winc;
            wq2_rptr = vecs[i].rptr;
            @(posedge wclk);
            #1;
            chk_all($sformatf("vec%0d", i), vecs[i].waddr, vecs[i].wptr, vecs[i].wfull,
                    vecs[i].awfull, vecs[i].wovf);
            @(negedge wclk);
        end

        // Reset clears sticky overflow and full state
        wq2_rptr = 5'b00000;
        pulse_reset("rst_after_ovf");

        // Wrap-around: 32 writes with the read pointer trailing by two
        wb       = 5'd0;
        saw_full = 1'b0;
        for (int i = 0; i < 32; i++) begin
            winc = 1'b1;
            @(posedge wclk);
            #1;
            wb = wb + 5'd1;
            if (wfull) saw_full = 1'b1;
            chk($sformatf("wrap wptr %0d", i), 32'(wptr), 32'(gray(wb)));
            rb       = (wb >= 5'd2 || i >= 2) ? wb - 5'd2 : 5'd0;
            @(negedge wclk);
            wq2_rptr = gray(rb);
        end
        winc = 1'b0;
        chk("wrap final wptr", 32'(wptr), 32'd0);
        chk("wrap final waddr", 32'(waddr), 32'd0);
        chk("wrap wfull seen", 32'(saw_full), 32'd0);
        chk("wrap awfull", 32'(awfull), 32'd0);

        // Reset mid-fill after 10 writes
        wq2_rptr = 5'b00000;
        pulse_reset("rst_pre_fill");
        for (int i = 0; i < 10; i++) begin
            winc = 1'b1;
            @(posedge wclk);
            #1;
            @(negedge wclk);
        end
        chk("mid fill wptr", 32'(wptr), 32'(5'b01111));
        #2;
        wrst = 1'b1;
        winc = 1'b0;
        #1;
        chk_all("mid reset", 4'd0, 5'b00000, 1'b0, 1'b0, 1'b0);
        @(negedge wclk);
        wrst = 1'b0;
        winc = 1'b1;
        @(posedge wclk);
        #1;
        chk_all("post reset write", 4'd1, 5'b00001, 1'b0, 1'b0, 1'b0);
        winc = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wptr_full_ctrl.md
WPTR_FULL_CTRL -- requirements
Module: wptr_full_ctrl

Interface
REQ-001 SHALL have parameter ASIZE, default 4: address width; FIFO depth is 2^ASIZE; legal range ASIZE >= 2.
REQ-002 SHALL have parameter AWFULLSIZE, default 1: almost-full margin in entries; legal range 1..2^ASIZE-1.
REQ-003 SHALL have port wclk  input  1  write-domain clock; the block's only clock.
REQ-004 SHALL have port wrst  input  1  reset; asynchronous and active-high.
REQ-005 SHALL have port winc  input  1  write request for the current cycle.
REQ-006 SHALL have port wq2_rptr  input  ASIZE+1  Gray read pointer, already synchronized into wclk by a two-flop synchronizer.
REQ-007 SHALL have port waddr  output  ASIZE  binary RAM write address.
REQ-008 SHALL have port wptr  output  ASIZE+1  registered Gray write pointer, sent to the read-domain synchronizer.
REQ-009 SHALL have port wfull  output  1  registered full flag.
REQ-010 SHALL have port awfull  output  1  registered almost-full flag.
REQ-011 SHALL have port wovf  output  1  sticky overflow flag.

Function
REQ-012 SHALL hold an internal binary pointer wbin of ASIZE+1 bits.
REQ-013 SHALL accept a write when winc=1 and wfull=0 (both sampled at the wclk rising edge); wbin then increments by 1, modulo 2^(ASIZE+1).
REQ-014 SHALL leave wbin unchanged on a write request made while wfull=1 (write dropped).
REQ-015 SHALL drive waddr combinationally as wbin[ASIZE-1:0]; the accepted write targets the address present before the edge.
REQ-016 SHALL register wptr as the Gray code of the next wbin, where Gray(x) = x XOR (x>>1); wptr and wbin therefore update at the same edge.
REQ-017 SHALL change only one wptr bit per accepted write.
REQ-018 SHALL register wfull = 1 when Gray(next wbin) equals {~wq2_rptr[ASIZE:ASIZE-1], wq2_rptr[ASIZE-2:0]}, otherwise 0.
REQ-019 SHALL assert wfull at the same edge that accepts the 2^ASIZE-th unread write, with zero added latency.
REQ-020 SHALL release wfull at the first wclk edge after wq2_rptr advances, with no extra pipeline stage.
REQ-021 SHALL convert wq2_rptr from Gray to binary (rbin) combinationally, MSB-first XOR prefix.
REQ-022 SHALL compute fill level = (next wbin - rbin) modulo 2^(ASIZE+1), in ASIZE+1 bits.
REQ-023 SHALL register awfull = 1 when fill level >= 2^ASIZE - AWFULLSIZE.
REQ-024 SHALL keep awfull asserted whenever wfull is asserted.
REQ-025 SHALL set wovf on any edge where winc=1 and wfull=1, and hold it until reset.
REQ-026 SHALL compute wfull and awfull from the same next-pointer value when a write and an rptr change occur in the same cycle, so the flags stay consistent.
REQ-027 SHALL support wrap-around: after 2^(ASIZE+1) accepted writes, wbin returns to 0 with no special handling.

Reset
REQ-028 SHALL, while wrst=1, force wbin=0, wptr=0, wfull=0, awfull=0 and wovf=0, asynchronously and regardless of wclk.
REQ-029 SHALL resume normal operation at the first wclk edge after wrst deasserts; a write requested at that edge is accepted.
REQ-030 SHALL discard all progress on a reset asserted mid-operation; no pending state survives the reset.

Verification (ASIZE=4, AWFULLSIZE=1)
REQ-031 SHALL cover power-on reset: wrst=1 with no clock -> waddr=0, wptr=00000, wfull=0, awfull=0, wovf=0.
REQ-032 SHALL cover fill: wq2_rptr=00000, 16 consecutive writes -> awfull=1 after the 15th edge (wptr=01000); after the 16th edge wptr=11000 and wfull=1.
REQ-033 SHALL cover overflow: continuing from REQ-032, winc=1 for 3 more cycles -> wptr stays 11000, waddr stays 0, wovf=1 and stays 1.
REQ-034 SHALL cover release from full: continuing from REQ-033, wq2_rptr=00001 with winc=0 -> after 1 edge wfull=0 and awfull=1 (level 15).
REQ-035 SHALL cover wrap-around: 32 accepted writes with wq2_rptr tracking within 2 entries -> wptr returns to 00000, waddr=0, wfull never asserted.
REQ-036 SHALL cover reset mid-fill: wrst pulsed after 10 writes -> wptr=00000, awfull=0, wovf=0 immediately; first post-reset write gives wptr=00001.
